// File: rtl/fpu_issue_ctrl_if.sv
// ============================================================================
// Module   : fpu_issue_ctrl_if
// Brief    : Core / shared-FPU / register-file signal bundle for fpu_issue_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fpu_issue_ctrl_if;
  logic        issue_valid;
  logic [5:0]  issue_funct;
  logic [4:0]  issue_fd;
  logic        issue_ready;
  logic [2:0]  unit_op_sel;
  logic        unit_busy;
  logic [31:0] unit_z;
  logic        unit_aeqb;
  logic [7:0]  unit_status;
  logic        wb_valid;
  logic [4:0]  wb_fd;
  logic [31:0] wb_data;
  logic        cond_wr;
  logic        cond_val;
  logic        chk_valid;
  logic [4:0]  chk_fs;
  logic [4:0]  chk_ft;
  logic        hazard;
  logic        illegal;
  logic [7:0]  sticky_status;
  logic        status_clr;

  modport master (
    output issue_valid, issue_funct, issue_fd, unit_z, unit_aeqb, unit_status,
           chk_valid, chk_fs, chk_ft, status_clr,
    input  issue_ready, unit_op_sel, unit_busy, wb_valid, wb_fd, wb_data,
           cond_wr, cond_val, hazard, illegal, sticky_status
  );

  modport slave (
    input  issue_valid, issue_funct, issue_fd, unit_z, unit_aeqb, unit_status,
           chk_valid, chk_fs, chk_ft, status_clr,
    output issue_ready, unit_op_sel, unit_busy, wb_valid, wb_fd, wb_data,
           cond_wr, cond_val, hazard, illegal, sticky_status
  );
endinterface

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// ============================================================================
// Module   : fpu_issue_ctrl
// Brief    : Multi-cycle issue/writeback sequencer for the shared FP32 unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fpu_issue_ctrl #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_issue_ctrl_if.slave bus
);

  localparam int LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
  localparam int CW      = $clog2(LAT_MAX) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [4:0]    fd_q, fd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   result_q;
  logic          flag_q;
  logic [7:0]    sticky_q, sticky_d;
  logic          illegal_q, illegal_d;
  logic          capture;

  logic          dec_legal;
  logic [2:0]    dec_op;
  logic [CW-1:0] dec_lat;

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    dec_lat   = CW'(LAT_ADD);
    case (bus.issue_funct)
      6'h00: dec_op = OP_ADD;
      6'h01: dec_op = OP_SUB;
      6'h02: begin dec_op = OP_MUL; dec_lat = CW'(LAT_MUL); end
      6'h03: begin dec_op = OP_DIV; dec_lat = CW'(LAT_DIV); end
      6'h32: dec_op = OP_CMP;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fd_d      = fd_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.issue_valid) begin
          if (dec_legal) begin
            op_d    = dec_op;
            fd_d    = bus.issue_fd;
            cnt_d   = dec_lat;
            state_d = S_EXEC;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Clear takes effect before the OR so a coinciding capture survives.
  always_comb begin
    sticky_d = bus.status_clr ? 8'h00 : sticky_q;
    if (capture) sticky_d = sticky_d | bus.unit_status;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      fd_q      <= 5'd0;
      cnt_q     <= '0;
      result_q  <= 32'd0;
      flag_q    <= 1'b0;
      sticky_q  <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fd_q      <= fd_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      illegal_q <= illegal_d;
      if (capture) begin
        result_q <= bus.unit_z;
        flag_q   <= bus.unit_aeqb;
      end
    end
  end

  // Every output is gated by rst_n so an aborted op can never write back.
  logic in_wb, is_cmp;
  assign in_wb  = rst_n && (state_q == S_WB);
  assign is_cmp = (op_q == OP_CMP);

  assign bus.issue_ready   = rst_n && (state_q == S_IDLE);
  assign bus.unit_busy     = rst_n && (state_q == S_EXEC);
  assign bus.unit_op_sel   = rst_n ? op_q : 3'd0;
  assign bus.wb_valid      = in_wb && !is_cmp;
  assign bus.wb_fd         = bus.wb_valid ? fd_q : 5'd0;
  assign bus.wb_data       = bus.wb_valid ? result_q : 32'd0;
  assign bus.cond_wr       = in_wb && is_cmp;
  assign bus.cond_val      = bus.cond_wr && flag_q;
  assign bus.illegal       = rst_n && illegal_q;
  assign bus.sticky_status = rst_n ? sticky_q : 8'h00;
  assign bus.hazard        = rst_n && bus.chk_valid && (state_q != S_IDLE) &&
                             (is_cmp || (bus.chk_fs == fd_q) || (bus.chk_ft == fd_q));

endmodule

`default_nettype wire
